// File: rtl/i2s_rx_frontend.sv
// I2S ADC receiver: synchronises bclk/lrclk/adcdat into clk and emits one signed stereo pair per frame.
// Optional frame_err pulse output is enabled by defining I2S_FRAME_ERR_EN.
module i2s_rx_frontend #(
  parameter int width       = 24,
  parameter int sync_stages = 2,
  parameter int max_slot    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_adcdat,
  output logic signed [width-1:0] sam_left,
  output logic signed [width-1:0] sam_right,
  output logic                    sam_valid
`ifdef I2S_FRAME_ERR_EN
  ,
  output logic                    frame_err
`endif
);

  localparam int CW = $clog2(max_slot + 2);
  localparam logic [CW-1:0]    CNT_SAT  = CW'(max_slot + 1);
  localparam logic [CW-1:0]    CNT_MIN  = CW'(width);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(max_slot);
  localparam logic [width-1:0] MSB_MASK = {1'b1, {(width-1){1'b0}}};

  typedef enum logic [1:0] {SYNC_WAIT, LEFT, RIGHT} state_e;

  logic [sync_stages-1:0] bclk_sync_q, lr_sync_q, dat_sync_q;
  logic                   bclk_hist_q, lr_prev_q, lr_prev_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [width-1:0]       shift_q, shift_d;
  logic [width-1:0]       hold_q, hold_d;
  logic                   left_bad_q, left_bad_d;
  logic [width-1:0]       right_q, right_d;
  logic                   commit_q, commit_d;
  logic [width-1:0]       sam_left_q, sam_left_d;
  logic [width-1:0]       sam_right_q, sam_right_d;
  logic                   sam_valid_q;

  logic             bclk_s, lr_s, dat_s, rise, boundary, slot_bad;
  logic [CW-1:0]    cnt_inc;
  logic [width-1:0] word_cur;

  assign bclk_s   = bclk_sync_q[sync_stages-1];
  assign lr_s     = lr_sync_q[sync_stages-1];
  assign dat_s    = dat_sync_q[sync_stages-1];
  assign rise     = bclk_s & ~bclk_hist_q;
  assign boundary = rise & (lr_s ^ lr_prev_q);
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  // Bit n of the slot lands at position width-1-n; bits past width shift the mask out entirely.
  assign word_cur = dat_s ? (shift_q | (MSB_MASK >> cnt_q)) : shift_q;
  assign slot_bad = (cnt_inc < CNT_MIN) || (cnt_inc > CNT_MAX);

  always_comb begin
    state_d     = state_q;
    lr_prev_d   = lr_prev_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    left_bad_d  = left_bad_q;
    right_d     = right_q;
    commit_d    = 1'b0;
    sam_left_d  = sam_left_q;
    sam_right_d = sam_right_q;
    if (commit_q) begin
      sam_left_d  = hold_q;
      sam_right_d = right_q;
    end
    if (rise) begin
      lr_prev_d = lr_s;
      cnt_d     = cnt_inc;
      shift_d   = word_cur;
    end
    if (boundary) begin
      cnt_d   = '0;
      shift_d = '0;
      unique case (state_q)
        SYNC_WAIT: if (!lr_s) state_d = LEFT;
        LEFT: if (lr_s) begin
          hold_d     = word_cur;
          left_bad_d = slot_bad;
          state_d    = RIGHT;
        end
        RIGHT: if (!lr_s) begin
          right_d  = word_cur;
          commit_d = !(left_bad_q || slot_bad);
          state_d  = LEFT;
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      dat_sync_q  <= '0;
      bclk_hist_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      state_q     <= SYNC_WAIT;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      left_bad_q  <= 1'b0;
      right_q     <= '0;
      commit_q    <= 1'b0;
      sam_left_q  <= '0;
      sam_right_q <= '0;
      sam_valid_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[sync_stages-2:0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[sync_stages-2:0], i2s_lrclk};
      dat_sync_q  <= {dat_sync_q[sync_stages-2:0], i2s_adcdat};
      bclk_hist_q <= bclk_s;
      lr_prev_q   <= lr_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      left_bad_q  <= left_bad_d;
      right_q     <= right_d;
      commit_q    <= commit_d;
      sam_left_q  <= sam_left_d;
      sam_right_q <= sam_right_d;
      sam_valid_q <= commit_q;
    end
  end

  assign sam_left  = sam_left_q;
  assign sam_right = sam_right_q;
  assign sam_valid = sam_valid_q;

`ifdef I2S_FRAME_ERR_EN
  logic drop_q, frame_err_q;

  // Error pulse is delayed to line up with where sam_valid would have fired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      drop_q      <= boundary && (state_q == RIGHT) && !lr_s && (left_bad_q || slot_bad);
      frame_err_q <= drop_q;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule
